// File: rtl/pe_multibank.sv
// Weight-stationary systolic PE with NUM_BANKS independently loadable
// weight banks. The A-flow (top-down) carries weight tokens that are
// captured by the PE whose ROW_ID matches the token index. The B-flow
// (left-right) carries activations and partial sums, plus a bank switch
// request that selects which bank feeds the multiplier.
//
// Timing rules:
//   - A MAC always reads the bank selected by act_ptr_q and the bank
//     contents as they were before the current edge. A same-cycle write
//     or switch therefore only affects the following cycle's MAC.
//   - pe_enabled=0 freezes every register, including banks and act_ptr.
//
// There is no handshake: every registered output is a plain
// one-cycle-delayed copy or result. A token is "valid" only while its
// valid flag (pe_accept_w_out / pe_valid_out) is 1, and the PE never
// stalls its neighbours.
module pe_multibank #(
  parameter int ROW_ID               = 0,
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int DATA_WIDTH_IN        = 8,
  parameter int DATA_WIDTH_ACCUM     = 32,
  parameter int NUM_BANKS            = 4,
  parameter int SATURATE             = 0,
  localparam int IW = $clog2(SYSTOLIC_ARRAY_WIDTH),
  localparam int BW = $clog2(NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pe_enabled,
  // A-flow (weights)
  input  logic                        pe_accept_w_in,
  input  logic [DATA_WIDTH_IN-1:0]    pe_weight_in,
  input  logic [IW-1:0]               pe_index_in,
  input  logic [BW-1:0]               pe_bank_wr_in,
  output logic [DATA_WIDTH_IN-1:0]    pe_weight_out,
  output logic [IW-1:0]               pe_index_out,
  output logic [BW-1:0]               pe_bank_wr_out,
  output logic                        pe_accept_w_out,
  // B-flow (activations / partial sums)
  input  logic                        pe_valid_in,
  input  logic                        pe_switch_in,
  input  logic [BW-1:0]               pe_bank_sel_in,
  input  logic [DATA_WIDTH_IN-1:0]    pe_input_in,
  input  logic [DATA_WIDTH_ACCUM-1:0] pe_psum_in,
  output logic [DATA_WIDTH_IN-1:0]    pe_input_out,
  output logic                        pe_valid_out,
  output logic                        pe_switch_out,
  output logic [BW-1:0]               pe_bank_sel_out,
  output logic [DATA_WIDTH_ACCUM-1:0] pe_psum_out,
  output logic                        pe_sat_out
);

  localparam int DW = DATA_WIDTH_IN;
  localparam int AW = DATA_WIDTH_ACCUM;
  localparam int PW = 2 * DATA_WIDTH_IN;

  localparam logic [IW-1:0] ROW_IDX    = IW'(ROW_ID);
  localparam logic [BW:0]   BANK_LIMIT = (BW + 1)'(NUM_BANKS);

  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW - 1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW - 1){1'b0}}};

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  logic [DW-1:0] weight_q, weight_d;
  logic [IW-1:0] index_q, index_d;
  logic [BW-1:0] bank_wr_q, bank_wr_d;
  logic          accept_w_q, accept_w_d;

  logic [DW-1:0] input_q, input_d;
  logic          valid_q, valid_d;
  logic          switch_q, switch_d;
  logic [BW-1:0] bank_sel_q, bank_sel_d;
  logic [AW-1:0] psum_q, psum_d;
  logic          sat_q, sat_d;

  logic [DW-1:0] bank_q [NUM_BANKS];
  logic [BW-1:0] act_ptr_q, act_ptr_d;

  // ---------------------------------------------------------------------
  // Combinational decode and datapath
  // ---------------------------------------------------------------------
  logic                 row_match;
  logic                 wr_bank_ok;
  logic                 wr_en;
  logic                 sel_bank_ok;
  logic signed [DW-1:0] act_weight;
  logic signed [PW-1:0] product;
  logic signed [AW:0]   full_sum;
  logic                 ovf;
  logic [AW-1:0]        mac_result;

  assign row_match   = (pe_index_in == ROW_IDX);
  assign wr_bank_ok  = ({1'b0, pe_bank_wr_in} < BANK_LIMIT);
  assign wr_en       = pe_accept_w_in && row_match && wr_bank_ok;
  assign sel_bank_ok = ({1'b0, pe_bank_sel_in} < BANK_LIMIT);

  // Read the active bank through an explicit mux so an unused pointer
  // code (non power-of-two NUM_BANKS) reads zero rather than out of range.
  always_comb begin
    act_weight = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (act_ptr_q == BW'(b)) begin
        act_weight = $signed(bank_q[b]);
      end
    end
  end

  // Product at 2*DW signed, sum at AW+1 bits so overflow is visible.
  assign product  = $signed(pe_input_in) * act_weight;
  assign full_sum = $signed({{(AW + 1 - PW){product[PW-1]}}, product})
                  + $signed({pe_psum_in[AW-1], pe_psum_in});

  // Top two bits disagree exactly when the sum leaves the AW-bit range.
  assign ovf = full_sum[AW] ^ full_sum[AW-1];

  // Clamp toward the sign of the true sum, or wrap to the low AW bits.
  always_comb begin
    mac_result = full_sum[AW-1:0];
    if ((SATURATE != 0) && ovf) begin
      mac_result = full_sum[AW] ? ACC_MIN : ACC_MAX;
    end
  end

  // Next-state for A-flow pass-through; a matching token is consumed here.
  always_comb begin
    weight_d   = pe_weight_in;
    index_d    = pe_index_in;
    bank_wr_d  = pe_bank_wr_in;
    accept_w_d = pe_accept_w_in && !row_match;
  end

  // Next-state for B-flow pass-through and MAC result.
  always_comb begin
    input_d    = pe_input_in;
    valid_d    = pe_valid_in;
    switch_d   = pe_switch_in;
    bank_sel_d = pe_bank_sel_in;
    psum_d     = '0;
    sat_d      = 1'b0;
    if (pe_valid_in) begin
      psum_d = mac_result;
      sat_d  = ovf;
    end
  end

  // Next active bank; out-of-range selections are ignored.
  always_comb begin
    act_ptr_d = act_ptr_q;
    if (pe_switch_in && sel_bank_ok) begin
      act_ptr_d = pe_bank_sel_in;
    end
  end

  // ---------------------------------------------------------------------
  // Sequential
  // ---------------------------------------------------------------------

  // A-flow pass-through registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      weight_q   <= '0;
      index_q    <= '0;
      bank_wr_q  <= '0;
      accept_w_q <= 1'b0;
    end else if (pe_enabled) begin
      weight_q   <= weight_d;
      index_q    <= index_d;
      bank_wr_q  <= bank_wr_d;
      accept_w_q <= accept_w_d;
    end
  end

  // B-flow pass-through and MAC output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      input_q    <= '0;
      valid_q    <= 1'b0;
      switch_q   <= 1'b0;
      bank_sel_q <= '0;
      psum_q     <= '0;
      sat_q      <= 1'b0;
    end else if (pe_enabled) begin
      input_q    <= input_d;
      valid_q    <= valid_d;
      switch_q   <= switch_d;
      bank_sel_q <= bank_sel_d;
      psum_q     <= psum_d;
      sat_q      <= sat_d;
    end
  end

  // Weight banks: a matching token writes exactly one bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_q[b] <= '0;
      end
    end else if (pe_enabled && wr_en) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (pe_bank_wr_in == BW'(b)) begin
          bank_q[b] <= pe_weight_in;
        end
      end
    end
  end

  // Active bank pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_ptr_q <= '0;
    end else if (pe_enabled) begin
      act_ptr_q <= act_ptr_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign pe_weight_out   = weight_q;
  assign pe_index_out    = index_q;
  assign pe_bank_wr_out  = bank_wr_q;
  assign pe_accept_w_out = accept_w_q;
  assign pe_input_out    = input_q;
  assign pe_valid_out    = valid_q;
  assign pe_switch_out   = switch_q;
  assign pe_bank_sel_out = bank_sel_q;
  assign pe_psum_out     = psum_q;
  assign pe_sat_out      = sat_q;

endmodule

// File: doc/pe_multibank.md
Name: pe_multibank

Overview:
- Next-generation weight-stationary systolic PE: the single shadow/active weight pair becomes NUM_BANKS independently loadable weight banks.
- The B-flow switch selects which bank is active, so several weight tiles can be preloaded and swapped with zero bubbles.
- Adds an optional saturating accumulate with a per-cycle overflow flag.
- Drop-in replacement for the existing PE inside the systolic array row/column fabric; same A-flow (weights, top-down) and B-flow (inputs/psums) topology.

Parameters:
ROW_ID, 0, row position; PE captures A-flow tokens whose index equals this
SYSTOLIC_ARRAY_WIDTH, 16, array width; index width = $clog2(SYSTOLIC_ARRAY_WIDTH)
DATA_WIDTH_IN, 8, signed weight/input width
DATA_WIDTH_ACCUM, 32, signed psum width
NUM_BANKS, 4, weight banks (>=2); bank index width BW = $clog2(NUM_BANKS)
SATURATE, 0, 1 = clamp accumulate to signed ACCUM range; 0 = two's-complement wrap

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
pe_enabled  in  1  global enable; 0 freezes all state
pe_accept_w_in  in  1  A-flow token valid
pe_weight_in  in  DATA_WIDTH_IN  A-flow weight (signed)
pe_index_in  in  $clog2(SYSTOLIC_ARRAY_WIDTH)  A-flow target row
pe_bank_wr_in  in  BW  A-flow target bank
pe_weight_out  out  DATA_WIDTH_IN  registered weight pass-through
pe_index_out  out  $clog2(SYSTOLIC_ARRAY_WIDTH)  registered index pass-through
pe_bank_wr_out  out  BW  registered bank pass-through
pe_accept_w_out  out  1  registered token valid (cleared when consumed here)
pe_valid_in  in  1  B-flow valid
pe_switch_in  in  1  B-flow bank switch request
pe_bank_sel_in  in  BW  bank to activate on switch
pe_input_in  in  DATA_WIDTH_IN  B-flow activation (signed)
pe_psum_in  in  DATA_WIDTH_ACCUM  incoming partial sum (signed)
pe_input_out  out  DATA_WIDTH_IN  registered input pass-through
pe_valid_out  out  1  registered valid
pe_switch_out  out  1  registered switch
pe_bank_sel_out  out  BW  registered bank select
pe_psum_out  out  DATA_WIDTH_ACCUM  registered MAC result
pe_sat_out  out  1  registered overflow flag for the cycle's MAC

Behaviour:
- Reset (rst=0, async, any time including mid-stream): all outputs = 0; all banks = 0; active pointer act_ptr = 0. Operation resumes on the first rising edge after rst=1.
- pe_enabled=0: every register holds its value, including outputs, banks and act_ptr. No writes, no switches.
- All timing below assumes pe_enabled=1.
- A-flow (latency 1):
  - weight/index/bank_wr outputs <= inputs every cycle.
  - pe_accept_w_out <= pe_accept_w_in && (pe_index_in != ROW_ID).
  - On a match (accept && index==ROW_ID): bank[pe_bank_wr_in] <= pe_weight_in.
  - bank_wr_in >= NUM_BANKS: write dropped, token still consumed (accept_w_out=0).
  - accept=0: no write, accept_w_out=0.
- B-flow (latency 1): input/valid/switch/bank_sel outputs <= inputs every cycle.
  - valid_in=1: full = sext(pe_input_in * bank[act_ptr]) + sext(pe_psum_in), computed at DATA_WIDTH_ACCUM+1 bits; product formed at 2*DATA_WIDTH_IN signed.
  - ovf = full outside the signed ACCUM range.
  - SATURATE=1: psum_out <= clamp(full) to 2^(ACCUM-1)-1 / -2^(ACCUM-1).
  - SATURATE=0: psum_out <= full[ACCUM-1:0].
  - pe_sat_out <= ovf in both modes.
  - valid_in=0: psum_out <= 0, pe_sat_out <= 0.
- Switch:
  - switch_in=1 (regardless of valid_in): act_ptr <= pe_bank_sel_in at the same edge.
  - The MAC in that same cycle uses the OLD act_ptr; the new bank applies from the next cycle.
  - bank_sel_in >= NUM_BANKS: act_ptr unchanged.
- Simultaneous write to bank[act_ptr] and MAC: MAC reads the pre-write value; the new value is used from the next cycle.
- Simultaneous switch and write to the target bank: the next cycle's MAC sees the newly written weight.
- No internal state machine beyond act_ptr; PE carries no backpressure. Upstream owns token ordering.

Test Plan:
- ROW_ID=5: stream indices 15..0 with accept=1, index 5 carrying weight 10 to bank 2, others 8'hFF -> accept_w_out=1 for every index except 5 (0); only bank2 written; accept_w_out=0 one cycle after accept drops.
- After load: valid=1, input 2, psum 100, switch=1, sel=2 -> psum_out=100 (bank0=0). Next cycle input 3, psum 200, switch=0 -> 230. Next valid=0 -> psum_out=0.
- Load bank1=-7. Switch sel=1 while computing input 4, psum 0 under bank2 -> 40. Next input 4, psum 0 -> -28. Sel=3 (loaded 5) and sel=4 on NUM_BANKS=4 -> act_ptr stays 3.
- SATURATE=1: weight 127, input 127, psum 0x7FFFF000 -> psum_out=2147483647, sat=1. SATURATE=0 -> psum_out=-2147471615, sat=1.
- Same-cycle write of 9 to active bank (weight 10), input 1, psum 0 -> 10. Next cycle -> 9. pe_enabled=0 for 3 cycles -> all outputs frozen.
- Assert rst=0 asynchronously mid-B-flow (between edges) -> outputs 0 immediately. After release, input 5, psum 1 -> psum_out=1 (banks cleared, act_ptr=0).
